// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Abort,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    // state | meaning
    // IDLE  | waiting for Start; MTHI/MTLO writes accepted
    // CALC  | WIDTH shift-add / shift-subtract iterations
    // FIX   | sign correction and HI/LO write-back
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_res, neg_rem;
    logic [WIDTH-1:0] a_raw, a_mag, b_mag;
    logic [WIDTH-1:0] acc_hi, acc_lo;

    logic             start_ok, wr_result;
    logic             signed_in;
    logic [WIDTH-1:0] a_abs_in, b_abs_in;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_in = ~Op[0];
    assign a_abs_in  = (signed_in && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign b_abs_in  = (signed_in && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    assign start_ok  = (state == IDLE) && Start && !Abort;
    assign wr_result = (state == FIX) && !Abort;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : '0);
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, b_mag};
    assign div_ok    = ~div_trial[WIDTH];

    assign prod      = {acc_hi, acc_lo};
    assign prod_fix  = neg_res ? -prod : prod;
    assign quo_fix   = neg_res ? -acc_lo : acc_lo;
    assign rem_fix   = neg_rem ? -acc_hi : acc_hi;

    assign Busy = (state != IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_ok) state_nxt = CALC;
            CALC: begin
                if (Abort)                        state_nxt = IDLE;
                else if (cnt == CW'(WIDTH - 1))   state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_raw   <= '0;
            a_mag   <= '0;
            b_mag   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else if (start_ok) begin
            cnt     <= '0;
            is_div  <= Op[1];
            neg_res <= signed_in && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_rem <= signed_in && SrcA[WIDTH-1];
            a_raw   <= SrcA;
            a_mag   <= a_abs_in;
            b_mag   <= b_abs_in;
            acc_hi  <= '0;
            // multiply shifts the multiplier out of LO; divide shifts the dividend out
            acc_lo  <= Op[1] ? a_abs_in : b_abs_in;
        end else if (state == CALC && !Abort) begin
            cnt <= cnt + CW'(1);
            if (!is_div) begin
                acc_hi <= mul_sum[WIDTH:1];
                acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else begin
                acc_hi <= div_ok ? div_trial[WIDTH-1:0] : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Hi      <= '0;
            Lo      <= '0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            Done <= wr_result;
            if (start_ok) begin
                DivZero <= 1'b0;
            end else if (wr_result) begin
                if (!is_div) begin
                    Hi <= prod_fix[2*WIDTH-1:WIDTH];
                    Lo <= prod_fix[WIDTH-1:0];
                end else if (b_mag == '0) begin
                    Hi      <= a_raw;
                    Lo      <= '1;
                    DivZero <= 1'b1;
                end else begin
                    Hi <= rem_fix;
                    Lo <= quo_fix;
                end
            end else if (state == IDLE && !Start) begin
                if (HiWe) Hi <= WData;
                if (LoWe) Lo <= WData;
            end
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, MTHI/MTLO, abort and async reset.
module tb_mdu_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        Abort = 1'b0, HiWe = 1'b0, LoWe = 1'b0;
    logic [31:0] WData = '0;
    logic        Busy, Done, DivZero;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int errors = 0;

    mdu_ctrl #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Abort(Abort), .HiWe(HiWe), .LoWe(LoWe), .WData(WData),
        .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 CLK = ~CLK;

    // returns at the negedge after the Start edge
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b dz=%b hi=%h lo=%h required 0/0/0/0/0", Busy, Done, DivZero, Hi, Lo);
        end
        RST = 1'b0;
    endtask

    // op, a, b, hi, lo, divzero
    logic [1:0]  v_op [10] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
    logic [31:0] v_a  [10] = '{32'h5, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hF, 32'hFFFFFFF9, 32'hF,
                              32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h7};
    logic [31:0] v_b  [10] = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h2, 32'h0,
                              32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFA};
    logic [31:0] v_hi [10] = '{32'h0, 32'hFFFFFFFF, 32'h2, 32'h0, 32'hFFFFFFFF, 32'hF,
                              32'h0, 32'h1, 32'hFFFFFFF9, 32'hFFFFFFFF};
    logic [31:0] v_lo [10] = '{32'hF, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'h5, 32'hFFFFFFFD, 32'hFFFFFFFF,
                              32'h80000000, 32'h7FFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFD6};
    logic        v_dz [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic test_arith;
        int n;
        for (int i = 0; i < 10; i++) begin
            launch(v_op[i], v_a[i], v_b[i]);
            wait_idle(n);
            checks++;
            if (n != 33 || Done !== 1'b1) begin
                errors++;
                $display("FAIL latency[%0d]: busy_cycles=%0d done=%b required 33/1", i, n, Done);
            end
            checks++;
            if (Hi !== v_hi[i] || Lo !== v_lo[i] || DivZero !== v_dz[i]) begin
                errors++;
                $display("FAIL result[%0d]: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                         i, Hi, Lo, DivZero, v_hi[i], v_lo[i], v_dz[i]);
            end
            @(negedge CLK);
            checks++;
            if (Done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse[%0d]: done=%b required 0", i, Done);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [31:0] hi0, lo0;
        hi0 = Hi; lo0 = Lo;
        launch(2'b00, 32'h7, 32'h6);
        repeat (8) @(negedge CLK);
        Start = 1'b1; Op = 2'b11; SrcA = 32'h99; SrcB = 32'h4;
        LoWe = 1'b1; WData = 32'h1234;
        @(negedge CLK);
        Start = 1'b0; LoWe = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Hi !== hi0 || Lo !== lo0) begin
            errors++;
            $display("FAIL calc_stable: busy=%b hi=%h lo=%h required 1/%h/%h", Busy, Hi, Lo, hi0, lo0);
        end
        wait_idle(n);
        checks++;
        if (n != 24 || Done !== 1'b1 || Hi !== 32'h0 || Lo !== 32'h2A) begin
            errors++;
            $display("FAIL ignore_mid: cycles=%0d done=%b hi=%h lo=%h required 24/1/0/2a", n, Done, Hi, Lo);
        end
        LoWe = 1'b1; WData = 32'h1234;
        @(negedge CLK);
        LoWe = 1'b0;
        checks++;
        if (Lo !== 32'h1234 || Hi !== 32'h0 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h hi=%h busy=%b required 1234/0/0", Lo, Hi, Busy);
        end
    endtask

    task automatic test_abort;
        int n;
        HiWe = 1'b1; LoWe = 1'b1; WData = 32'hAAAA;
        @(negedge CLK);
        LoWe = 1'b0; HiWe = 1'b0;
        LoWe = 1'b1; WData = 32'h5555;
        @(negedge CLK);
        LoWe = 1'b0;
        checks++;
        if (Hi !== 32'hAAAA || Lo !== 32'h5555) begin
            errors++;
            $display("FAIL mthi_mtlo: hi=%h lo=%h required aaaa/5555", Hi, Lo);
        end
        Start = 1'b1; Abort = 1'b1; Op = 2'b00; SrcA = 32'h3; SrcB = 32'h3;
        @(negedge CLK);
        Start = 1'b0; Abort = 1'b0;
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_start: busy=%b required 0", Busy);
        end
        launch(2'b01, 32'hFFFF, 32'hFFFF);
        repeat (9) @(negedge CLK);
        Abort = 1'b1;
        @(negedge CLK);
        Abort = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'hAAAA || Lo !== 32'h5555) begin
            errors++;
            $display("FAIL abort: busy=%b done=%b hi=%h lo=%h required 0/0/aaaa/5555", Busy, Done, Hi, Lo);
        end
        Start = 1'b1; Op = 2'b01; SrcA = 32'h10000; SrcB = 32'h10000;
        @(negedge CLK);
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL restart: busy=%b done=%b required 1/0", Busy, Done);
        end
        wait_idle(n);
        checks++;
        if (n != 33 || Done !== 1'b1 || Hi !== 32'h1 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL restart_result: cycles=%0d done=%b hi=%h lo=%h required 33/1/1/0", n, Done, Hi, Lo);
        end
    endtask

    task automatic test_async_reset;
        int seen;
        launch(2'b10, 32'h64, 32'h7);
        repeat (5) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if (Busy !== 1'b0 || Hi !== 32'h0 || Lo !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy=%b hi=%h lo=%h required 0/0/0", Busy, Hi, Lo);
        end
        @(negedge CLK);
        RST = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done === 1'b1 || Busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL post_reset: busy_or_done_cycles=%0d required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit for the MIPS EX stage. Owns the HI/LO architectural registers.
- Sequences an iterative radix-2 shift-add multiplier and a restoring divider for MULT/MULTU/DIV/DIVU.
- Services MTHI/MTLO writes and provides HI/LO for MFHI/MFLO.
- Exposes Busy so the pipeline controller can stall while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and iteration count. Latency derives from it; only 32 is verified.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Start  in  1  launch operation; sampled only in IDLE.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  in  WIDTH  rs value: multiplicand / dividend.
- SrcB  in  WIDTH  rt value: multiplier / divisor.
- Abort  in  1  cancel in-flight operation (pipeline flush).
- HiWe  in  1  MTHI write enable.
- LoWe  in  1  MTLO write enable.
- WData  in  WIDTH  MTHI/MTLO data.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse when HI/LO updated by an operation.
- DivZero  out  1  valid with Done: last division had SrcB==0.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
Reset:
- RST=1 asynchronously forces state IDLE; Hi=Lo=0; Busy=Done=DivZero=0; iteration counter=0.
- Holds regardless of CLK. Reset mid-operation discards all partial results.

States: IDLE, CALC, FIX.
- IDLE:
  - Start=1 at edge E0 latches Op, absolute values (signed ops) or raw operands (unsigned ops), and the sign flags; clears the accumulator; counter=0; goes to CALC.
  - Busy=1 from E0.
- CALC:
  - One iteration per edge: multiply shift-add, or divide shift-subtract-restore, LSB-first / MSB-first respectively.
  - Counter increments per iteration; after WIDTH iterations (E1..E32) goes to FIX.
- FIX, edge E33:
  - Applies sign correction and writes HI/LO.
  - Done=1 and Busy=0 during the cycle after E33; returns to IDLE.
  - Result is therefore visible WIDTH+1 edges after the Start edge.

Arithmetic:
- MULT/MULTU: {Hi,Lo} = 64-bit product. Signed: negate the 64-bit magnitude product iff the operand signs differ.
- DIV/DIVU: Lo = quotient, Hi = remainder.
  - Signed: quotient negated iff the signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives Lo=0x80000000, Hi=0. No trap.
- Divide by zero: full latency is still taken; Lo=0xFFFFFFFF, Hi=SrcA (original, unsigned view); DivZero=1.
- DivZero is cleared at the next Start.

Simultaneous/boundary:
- Start while Busy: ignored, no queuing.
- HiWe/LoWe:
  - Applied at the edge only in IDLE with Start=0.
  - Ignored while Busy or when Start=1 in the same cycle; Start wins.
  - HiWe and LoWe together write both registers.
- Abort:
  - Abort=1 in CALC or FIX returns to IDLE at the next edge; HI/LO unchanged; no Done.
  - Abort in IDLE has no effect. Abort together with Start in IDLE: Start is dropped.
- Hi/Lo are stable during CALC; they keep their pre-operation values until the FIX edge.
- Done never asserts in two consecutive cycles.

Test Plan:
- MULT SrcA=5, SrcB=3 after reset -> Busy high for 33 cycles; Done pulse one cycle after E33; Hi=0x00000000, Lo=0x0000000F.
- MULT 0xFFFFFFFE × 3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MULTU with same operands -> Hi=0x00000002, Lo=0xFFFFFFFA.
- DIV 0x0000000F/3 -> Lo=5, Hi=0; DIV 0xFFFFFFF9/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 0x0000000F/0 -> Lo=0xFFFFFFFF, Hi=0x0000000F, DivZero=1.
- Second Start and LoWe (WData=0x1234) pulsed mid-operation -> both ignored; the first result lands intact. LoWe in IDLE -> Lo=0x00001234 next edge.
- Abort at CALC iteration 10 with Hi/Lo=0xAAAA/0x5555 -> IDLE next edge, no Done, Hi/Lo unchanged; a new Start is accepted immediately.
- RST asserted asynchronously mid-CALC (between edges) -> Busy=0 and Hi=Lo=0 immediately; no Done after release.
